// File: rtl/ppu_pkg.sv
// Shared PPU definitions: sprite attribute word layout, raster timing
// landmarks and the sprite evaluator state encoding.
package ppu_pkg;

  localparam int ATTR_Y_LSB     = 0;
  localparam int ATTR_Y_MSB     = 9;
  localparam int ATTR_X_LSB     = 10;
  localparam int ATTR_X_MSB     = 19;
  localparam int ATTR_TILE_LSB  = 20;
  localparam int ATTR_TILE_MSB  = 27;
  localparam int ATTR_COLOR_LSB = 28;
  localparam int ATTR_COLOR_MSB = 31;

  localparam logic [10:0] HACTIVE_END = 11'd1280;
  localparam logic [10:0] HDEADLINE   = 11'd1598;
  localparam logic [10:0] HLAST       = 11'd1599;
  localparam logic [9:0]  VACTIVE     = 10'd480;
  localparam logic [9:0]  VLAST       = 10'd524;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } eval_state_e;

endpackage

// File: rtl/sprite_evaluator_if.sv
// Attribute-memory port and pixel-slot load bus between the sprite evaluator
// (master) and the PPU datapath that owns the RAM and slots (slave).
interface sprite_evaluator_if #(
  parameter int NUM_SLOTS = 8
);
  logic                 host_busy;
  logic [3:0]           attr_addr;
  logic [31:0]          attr_data;
  logic [NUM_SLOTS-1:0] slot_ld;
  logic [9:0]           slot_x;
  logic [3:0]           slot_row;
  logic [7:0]           slot_tile;
  logic [3:0]           slot_color;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic                 line_start;
  logic                 overflow;
  logic                 late;

  modport master (
    input  host_busy, attr_data,
    output attr_addr, slot_ld, slot_x, slot_row, slot_tile, slot_color,
           slot_valid, line_start, overflow, late
  );

  modport slave (
    output host_busy, attr_data,
    input  attr_addr, slot_ld, slot_x, slot_row, slot_tile, slot_color,
           slot_valid, line_start, overflow, late
  );
endinterface

// File: rtl/sprite_evaluator.sv
// Scans the sprite attribute table during horizontal blanking and loads the
// sprites that cover the next line into pixel slots, lowest index first.
module sprite_evaluator
  import ppu_pkg::*;
#(
  parameter int NUM_ATTRS = 16,
  parameter int NUM_SLOTS = 8,
  parameter int SPRITE_H  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  sprite_evaluator_if.master bus
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  eval_state_e          state_r;
  logic [3:0]           idx_r;
  logic [CNT_W-1:0]     slot_count_r;
  logic [9:0]           target_line_r;
  logic [3:0]           attr_addr_r;
  logic [NUM_SLOTS-1:0] slot_ld_r;
  logic [9:0]           slot_x_r;
  logic [3:0]           slot_row_r;
  logic [7:0]           slot_tile_r;
  logic [3:0]           slot_color_r;
  logic [NUM_SLOTS-1:0] slot_valid_r;
  logic                 line_start_r;
  logic                 overflow_r;
  logic                 late_r;

  logic [9:0]           next_line_s;
  logic [9:0]           attr_y_s;
  logic [9:0]           attr_x_s;
  logic [7:0]           attr_tile_s;
  logic [3:0]           attr_color_s;
  logic [10:0]          diff_s;
  logic                 hit_s;
  logic                 deadline_s;
  logic                 last_idx_s;
  logic                 slots_full_s;
  logic [NUM_SLOTS-1:0] slot_onehot_s;

  assign next_line_s   = (vcount == VLAST) ? 10'd0 : vcount + 10'd1;
  assign attr_y_s      = bus.attr_data[ATTR_Y_MSB:ATTR_Y_LSB];
  assign attr_x_s      = bus.attr_data[ATTR_X_MSB:ATTR_X_LSB];
  assign attr_tile_s   = bus.attr_data[ATTR_TILE_MSB:ATTR_TILE_LSB];
  assign attr_color_s  = bus.attr_data[ATTR_COLOR_MSB:ATTR_COLOR_LSB];
  // 11-bit compare so y near 1023 cannot alias onto low line numbers
  assign diff_s        = {1'b0, target_line_r} - {1'b0, attr_y_s};
  assign hit_s         = ({1'b0, target_line_r} >= {1'b0, attr_y_s}) &&
                         (diff_s < 11'(SPRITE_H));
  assign deadline_s    = (hcount == HDEADLINE);
  assign last_idx_s    = (idx_r == 4'(NUM_ATTRS - 1));
  assign slots_full_s  = (slot_count_r == CNT_W'(NUM_SLOTS));
  assign slot_onehot_s = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot_count_r;

  assign bus.attr_addr  = attr_addr_r;
  assign bus.slot_ld    = slot_ld_r;
  assign bus.slot_x     = slot_x_r;
  assign bus.slot_row   = slot_row_r;
  assign bus.slot_tile  = slot_tile_r;
  assign bus.slot_color = slot_color_r;
  assign bus.slot_valid = slot_valid_r;
  assign bus.line_start = line_start_r;
  assign bus.overflow   = overflow_r;
  assign bus.late       = late_r;

  // Evaluation FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= 4'd0;
      slot_count_r  <= '0;
      target_line_r <= 10'd0;
      attr_addr_r   <= 4'd0;
      slot_ld_r     <= '0;
      slot_x_r      <= 10'd0;
      slot_row_r    <= 4'd0;
      slot_tile_r   <= 8'd0;
      slot_color_r  <= 4'd0;
      slot_valid_r  <= '0;
      line_start_r  <= 1'b0;
      overflow_r    <= 1'b0;
      late_r        <= 1'b0;
    end else begin
      slot_ld_r    <= '0;
      attr_addr_r  <= 4'd0;
      // Raised one edge early so the pulse coincides with the hcount==1599 cycle
      line_start_r <= deadline_s && (state_r != IDLE) && (target_line_r < VACTIVE);
      case (state_r)
        IDLE: begin
          if (hcount == HACTIVE_END) begin
            target_line_r <= next_line_s;
            idx_r         <= 4'd0;
            slot_count_r  <= '0;
            slot_valid_r  <= '0;
            overflow_r    <= 1'b0;
            late_r        <= 1'b0;
            if (next_line_s >= VACTIVE) begin
              state_r <= DONE;
            end else begin
              state_r <= FETCH;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH: begin
          if (deadline_s) begin
            late_r  <= 1'b1;
            state_r <= DONE;
          end else if (bus.host_busy) begin
            attr_addr_r <= idx_r;
            state_r     <= FETCH;
          end else begin
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (deadline_s) begin
            late_r  <= 1'b1;
            state_r <= DONE;
          end else if (hit_s && !slots_full_s) begin
            slot_ld_r    <= slot_onehot_s;
            slot_x_r     <= attr_x_s;
            slot_row_r   <= diff_s[3:0];
            slot_tile_r  <= attr_tile_s + {4'd0, diff_s[3:0]};
            slot_color_r <= attr_color_s;
            slot_valid_r <= slot_valid_r | slot_onehot_s;
            slot_count_r <= slot_count_r + CNT_W'(1);
            state_r      <= LOAD;
          end else begin
            if (hit_s) begin
              overflow_r <= 1'b1;
            end else begin
              overflow_r <= overflow_r;
            end
            if (last_idx_s) begin
              state_r <= DONE;
            end else begin
              idx_r       <= idx_r + 4'd1;
              attr_addr_r <= idx_r + 4'd1;
              state_r     <= FETCH;
            end
          end
        end
        LOAD: begin
          if (deadline_s) begin
            late_r  <= 1'b1;
            state_r <= DONE;
          end else if (last_idx_s) begin
            state_r <= DONE;
          end else begin
            idx_r       <= idx_r + 4'd1;
            attr_addr_r <= idx_r + 4'd1;
            state_r     <= FETCH;
          end
        end
        DONE: begin
          if (hcount == HLAST) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_evaluator.sv
// Self-checking bench for sprite_evaluator: boundary vector table, directed
// scans (overflow, deadline, mid-scan reset) and randomized attribute tables.
module tb_sprite_evaluator;
  localparam int NA = 16;
  localparam int NS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;

  sprite_evaluator_if #(.NUM_SLOTS(NS)) bus();

  sprite_evaluator #(.NUM_ATTRS(NA), .NUM_SLOTS(NS), .SPRITE_H(16)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .bus(bus)
  );

  always #10 clk = ~clk;

  // Synchronous attribute RAM; returns junk while the host owns the port.
  logic [31:0] mem [NA];
  always @(posedge clk) bus.attr_data <= bus.host_busy ? 32'hDEAD_BEEF : mem[bus.attr_addr];

  typedef struct { int ld; int x; int row; int tile; int color; int h; } load_t;
  typedef struct { int vc; int y; int exp_hit; int exp_row; int exp_ls; } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  load_t loads[$];
  load_t exp_q[$];
  int ls_cnt, ls_h, max_addr, bad_onehot, exp_ovf, exp_ls, tgt;
  logic [7:0] fin_valid;
  logic fin_ovf, fin_late;
  int prev_exp_valid = 0;
  bit hold_known = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int y, input int x, input int tile, input int color);
    return {4'(color), 8'(tile), 10'(x), 10'(y)};
  endfunction

  task automatic fill_empty();
    for (int i = 0; i < NA; i++) mem[i] = mk(1023, i * 37 + 1, i, i);
  endtask

  // Runs hcount 1275..1599 for one line, recording what the DUT does.
  task automatic run_line(input int vc, input int busy_lo, input int busy_hi,
                          input int busy_pct, input int reset_h);
    vcount = 10'(vc);
    loads.delete();
    ls_cnt = 0; ls_h = -1; max_addr = 0; bad_onehot = 0;
    for (int h = 1275; h <= 1599; h++) begin
      hcount = 11'(h);
      bus.host_busy = (h >= busy_lo && h <= busy_hi) ||
                      (busy_pct > 0 && h > 1280 && h < 1340 && $urandom_range(99) < busy_pct);
      reset = (h == reset_h);
      @(negedge clk);
      if (h == 1280 && hold_known) check("valid_hold", 32'(bus.slot_valid), 32'(prev_exp_valid));
      if (bus.slot_ld != '0) begin
        if ($countones(bus.slot_ld) != 1) bad_onehot++;
        loads.push_back('{int'(bus.slot_ld), int'(bus.slot_x), int'(bus.slot_row),
                          int'(bus.slot_tile), int'(bus.slot_color), h});
      end
      if (bus.line_start) begin ls_cnt++; ls_h = h; end
      if (int'(bus.attr_addr) > max_addr) max_addr = int'(bus.attr_addr);
      if (h == reset_h + 1) begin
        check("reset_clear_a", {bus.slot_ld, bus.slot_valid, bus.slot_tile, bus.slot_color, bus.attr_addr}, 32'd0);
        check("reset_clear_b", 32'({bus.slot_x, bus.slot_row, bus.line_start, bus.overflow, bus.late}), 32'd0);
      end
      if (h == 1599) begin
        fin_valid = bus.slot_valid; fin_ovf = bus.overflow; fin_late = bus.late;
      end
      @(posedge clk);
      #1;
    end
    bus.host_busy = 1'b0;
    reset = 1'b0;
  endtask

  // Reference: which table entries cover the target line, in priority order.
  task automatic model_line(input int vc);
    int y;
    exp_q.delete();
    exp_ovf = 0;
    tgt = (vc == 524) ? 0 : vc + 1;
    exp_ls = (tgt < 480) ? 1 : 0;
    if (tgt < 480) begin
      for (int i = 0; i < NA; i++) begin
        y = int'(mem[i][9:0]);
        if (tgt >= y && tgt - y < 16) begin
          if (exp_q.size() < NS)
            exp_q.push_back('{1 << exp_q.size(), int'(mem[i][19:10]), tgt - y,
                              (int'(mem[i][27:20]) + tgt - y) % 256, int'(mem[i][31:28]), 0});
          else
            exp_ovf = 1;
        end
      end
    end
  endtask

  task automatic check_line(input int exp_late);
    int n;
    n = exp_q.size();
    check("load_count", loads.size(), n);
    for (int k = 0; k < n && k < loads.size(); k++) begin
      check("slot_ld", loads[k].ld, exp_q[k].ld);
      check("slot_x", loads[k].x, exp_q[k].x);
      check("slot_row", loads[k].row, exp_q[k].row);
      check("slot_tile", loads[k].tile, exp_q[k].tile);
      check("slot_color", loads[k].color, exp_q[k].color);
    end
    check("slot_valid", 32'(fin_valid), 32'((1 << n) - 1));
    check("overflow", 32'(fin_ovf), 32'(exp_ovf));
    check("late", 32'(fin_late), 32'(exp_late));
    check("line_start_cnt", ls_cnt, exp_ls);
    if (exp_ls != 0) check("line_start_h", ls_h, 1599);
    if (exp_ls != 0 && exp_late == 0) check("last_addr", max_addr, NA - 1);
    check("onehot", bad_onehot, 0);
    prev_exp_valid = (1 << n) - 1;
    hold_known = 1'b1;
  endtask

  vec_t vecs[8];
  int late_loads, y_r;

  initial begin
    vecs[0] = '{24, 10, 1, 15, 1};
    vecs[1] = '{25, 10, 0, 0, 1};
    vecs[2] = '{8, 10, 0, 0, 1};
    vecs[3] = '{9, 10, 1, 0, 1};
    vecs[4] = '{524, 0, 1, 0, 1};
    vecs[5] = '{524, 1009, 0, 0, 1};
    vecs[6] = '{478, 470, 1, 9, 1};
    vecs[7] = '{479, 470, 0, 0, 0};

    reset = 1'b1; hcount = 11'd0; vcount = 10'd0; bus.host_busy = 1'b0;
    fill_empty();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_a", {bus.slot_ld, bus.slot_valid, bus.slot_tile, bus.slot_color, bus.attr_addr}, 32'd0);
    check("rst_out_b", 32'({bus.slot_x, bus.slot_row, bus.line_start, bus.overflow, bus.late}), 32'd0);
    reset = 1'b0;

    // Boundary table: a single candidate at index 0.
    for (int v = 0; v < 8; v++) begin
      fill_empty();
      mem[0] = mk(vecs[v].y, 200, 8'h10, 5);
      run_line(vecs[v].vc, -1, -1, 0, -1);
      check("vec_hit", loads.size(), vecs[v].exp_hit);
      if (loads.size() > 0 && vecs[v].exp_hit != 0) check("vec_row", loads[0].row, vecs[v].exp_row);
      check("vec_line_start", ls_cnt, vecs[v].exp_ls);
      prev_exp_valid = vecs[v].exp_hit;
    end

    // Single sprite at index 3.
    fill_empty();
    mem[3] = mk(5, 100, 8'h20, 4);
    run_line(10, -1, -1, 0, -1);
    model_line(10);
    check_line(0);
    if (loads.size() > 0) begin
      check("d40_x", loads[0].x, 100);
      check("d40_row", loads[0].row, 6);
      check("d40_tile", loads[0].tile, 8'h26);
      check("d40_color", loads[0].color, 4);
    end

    // Ten hits on one line: eight slots, overflow.
    fill_empty();
    for (int i = 0; i < 10; i++) mem[i] = mk(50, i * 10 + 1, i, i);
    run_line(49, -1, -1, 0, -1);
    model_line(49);
    check_line(0);
    check("d41_overflow", 32'(fin_ovf), 32'd1);
    check("d41_valid", 32'(fin_valid), 32'hFF);

    // Reset mid-scan, then the same line again.
    run_line(49, -1, -1, 0, 1290);
    late_loads = 0;
    foreach (loads[k]) if (loads[k].h > 1290) late_loads++;
    check("d45_no_load", late_loads, 0);
    check("d45_no_ls", ls_cnt, 0);
    prev_exp_valid = 0;
    run_line(49, -1, -1, 0, -1);
    model_line(49);
    check_line(0);

    // Host holds the port until 1590 with every entry hitting.
    for (int i = 0; i < NA; i++) mem[i] = mk(101, i * 17 + 3, i, 2);
    run_line(100, 1280, 1590, 0, -1);
    check("d44_late", 32'(fin_late), 32'd1);
    late_loads = 0;
    foreach (loads[k]) if (loads[k].h > 1598) late_loads++;
    check("d44_no_ld_after", late_loads, 0);
    for (int k = 0; k < loads.size() && k < NS; k++) begin
      check("d44_order_x", loads[k].x, k * 17 + 3);
      check("d44_order_ld", loads[k].ld, 1 << k);
    end
    check("d44_line_start", ls_h, 1599);
    hold_known = 1'b0;

    // Randomized attribute tables with light host contention.
    for (int r = 0; r < 25; r++) begin
      int vc;
      vc = ($urandom_range(4) == 0) ? int'($urandom_range(470, 524)) : int'($urandom_range(469));
      tgt = (vc == 524) ? 0 : vc + 1;
      for (int i = 0; i < NA; i++) begin
        case ($urandom_range(3))
          0: y_r = 1023 - int'($urandom_range(14));
          1: y_r = int'($urandom_range(1023));
          default: begin
            y_r = tgt - int'($urandom_range(20));
            if (y_r < 0) y_r = 0;
          end
        endcase
        mem[i] = mk(y_r, int'($urandom_range(1023)), int'($urandom_range(255)), int'($urandom_range(15)));
      end
      run_line(vc, -1, -1, 15, -1);
      model_line(vc);
      check_line(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_evaluator.md
SPRITE_EVALUATOR -- requirements
Module: sprite_evaluator

Interface
REQ-001 Parameter NUM_ATTRS, default 16: number of sprite attribute table entries scanned per line.
REQ-002 Parameter NUM_SLOTS, default 8: maximum sprites loaded into pixel slots per line.
REQ-003 Parameter SPRITE_H, default 16: sprite height in lines.
REQ-004 clk  input  1: single system clock, 50 MHz.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 hcount  input  11: horizontal counter, 0..1599, from vga_counters.
REQ-007 vcount  input  10: vertical counter, 0..524, from vga_counters.
REQ-008 host_busy  input  1: host owns the attribute memory port this cycle.
REQ-009 attr_addr  output  4: attribute table read address.
REQ-010 attr_data  input  32: attribute word; valid one cycle after attr_addr is presented (synchronous RAM).
REQ-011 slot_ld  output  NUM_SLOTS: one-hot, one-cycle load strobe for one pixel slot.
REQ-012 slot_x  output  10: sprite x for the loading slot; valid only while slot_ld is nonzero.
REQ-013 slot_row  output  4: row within the sprite for the line being prepared.
REQ-014 slot_tile  output  8: sprite table address for the loading slot.
REQ-015 slot_color  output  4: palette base for the loading slot.
REQ-016 slot_valid  output  NUM_SLOTS: slots loaded for the upcoming line.
REQ-017 line_start  output  1: one-cycle pulse marking the start of the prepared line.
REQ-018 overflow  output  1: more than NUM_SLOTS sprites hit the prepared line.
REQ-019 late  output  1: the scan was cut off by the deadline.

Function
REQ-020 Attribute word fields: y=[9:0], x=[19:10], tile=[27:20], color=[31:28].
REQ-021 States: IDLE, FETCH, CHECK, LOAD, DONE.
REQ-022 IDLE -> FETCH when hcount==1280.
- Same cycle: target_line = vcount+1, with 524 wrapping to 0.
- Same cycle: idx, slot_count, slot_valid, overflow and late clear to 0.
REQ-023 If target_line >= 480, IDLE -> DONE directly: no fetch, no loads.
REQ-024 FETCH drives attr_addr=idx.
- host_busy=1: stay in FETCH.
- host_busy=0: go to CHECK.
REQ-025 CHECK: hit when target_line >= y and target_line - y < SPRITE_H.
- Compute in 11-bit unsigned arithmetic; y values 1009..1023 never wrap.
REQ-026 CHECK, hit, slot_count < NUM_SLOTS: go to LOAD.
REQ-027 CHECK, hit, slot_count == NUM_SLOTS: set overflow=1 and skip the entry.
REQ-028 CHECK, miss or skip:
- idx==NUM_ATTRS-1: go to DONE.
- Otherwise: idx+1, go to FETCH.
REQ-029 LOAD lasts exactly one cycle.
- slot_ld[slot_count]=1.
- slot_x=x, slot_row=(target_line-y)[3:0], slot_tile=tile+slot_row, slot_color=color.
- slot_valid[slot_count] set; slot_count+1.
- Then same exit rule as REQ-028.
REQ-030 Priority: lower attribute index wins; slots fill in ascending index order.
REQ-031 Deadline: if hcount==1598 in FETCH, CHECK or LOAD, set late=1 and go to DONE.
- A LOAD in that cycle still completes.
REQ-032 DONE -> IDLE at hcount==1599.
- line_start=1 in that cycle iff target_line < 480.
REQ-033 slot_valid, overflow and late hold from DONE until the next IDLE->FETCH.
REQ-034 attr_addr=0 and slot_ld=0 in every state except FETCH and LOAD respectively.
REQ-035 Latency: without host_busy, 2 cycles per miss and 3 per hit; a full 16-entry scan finishes by hcount 1328.

Reset
REQ-036 On reset, all of the following go to 0 on the next clk edge:
- state to IDLE.
- idx, slot_count, target_line.
- attr_addr, slot_ld, slot_x, slot_row, slot_tile, slot_color, slot_valid, line_start, overflow, late.
REQ-037 Reset mid-scan discards partial results; no slot_ld or line_start until the next hcount==1280.

Structure
REQ-038 Package ppu_pkg holds the following, and the module imports it:
- Attribute field bit positions.
- Timing constants: HACTIVE_END=1280, HDEADLINE=1598, HLAST=1599, VACTIVE=480, VLAST=524.
- The state enum typedef.
REQ-039 Single module, no sub-module; the top-level PPU instantiates it and muxes attr_addr against host writes using host_busy.

Verification
REQ-040 vcount=10; attr[3] y=5, x=100, tile=0x20, color=4; others y=1023 -> exactly one slot_ld[0].
- slot_x=100, slot_row=6, slot_tile=0x26, slot_color=4.
- line_start at hcount 1599.
REQ-041 10 entries with y=50, vcount=49 -> slots 0..7 load indices 0..7 in order.
- overflow=1, late=0, slot_valid=0xFF.
REQ-042 vcount=524, attr[0] y=0 -> target_line=0 and slot_row=0.
- vcount=479 -> no fetch, line_start=0.
REQ-043 Boundary: y=10 with target 25 -> hit, row 15; target 26 -> miss; target 9 -> miss.
REQ-044 host_busy held from hcount 1280 to 1590, all entries hit -> late=1.
- DONE by 1599; no slot_ld after 1598.
REQ-045 reset pulsed at hcount 1290 mid-scan -> all outputs 0 next cycle.
- Next line scans normally from hcount 1280.
